sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Parametrised N-channel sprite compositor for the game video path. Each pixel is tested against N_SPR independently positioned sprite channels, each with its own texture RAM. The block resolves priority and colour-key transparency over the background pixel and accumulates pixel-exact collisions between channel 0 (player) and every other channel. It sits between the display timing generator / SDRAM background fetch and the video output encoder, and is the generalised successor of the fixed bird/pipe/ground renderer.

## Interface
Parameters:
- N_SPR, 4, number of sprite channels (2..8); channel 0 has highest priority and is the collision reference
- SPR_W, 64, sprite width in pixels
- SPR_H, 64, sprite height in pixels
- PIX_W, 16, pixel width (RGB565)
- COORD_W, 11, screen coordinate width
- KEY, 16'h07E0, transparent colour key

Ports:
- clk  in  1  pixel clock, single clock domain (loads included)
- rst_n  in  1  synchronous active-low reset
- pix_en  in  1  pixel_x/pixel_y/bg_data valid this cycle
- pixel_x, pixel_y  in  COORD_W each  current screen coordinate
- bg_data  in  PIX_W  background pixel aligned with pixel_x/y
- spr_x, spr_y  in  N_SPR*COORD_W  packed top-left positions, channel i at [i*COORD_W +: COORD_W]
- spr_en  in  N_SPR  channel enable
- spr_flip  in  N_SPR  horizontal mirror per channel
- load_en  in  1  texture write strobe
- load_sel  in  clog2(N_SPR)  target channel
- load_addr  in  clog2(SPR_W*SPR_H)  texel address, row-major
- load_data  in  PIX_W  texel value
- frame_en  in  1  one-cycle pulse at frame boundary
- pixel_out  out  PIX_W  composited pixel
- pixel_valid  out  1  pixel_out valid
- coll_frame  out  N_SPR-1  bit i-1 set if channel 0 overlapped channel i (both opaque) during the last completed frame

## Operation
- Hit test per channel i: spr_en[i] && pixel_x >= x_i && (pixel_x - x_i) < SPR_W && same for y; difference computed at COORD_W+1 bits, so sprites are clipped at screen edges and never wrap.
- dx = pixel_x - x_i; tx = spr_flip[i] ? SPR_W-1-dx : dx; texel address = dy*SPR_W + tx.
- Texel is opaque iff hit and texel != KEY. Output = opaque texel of the lowest-index opaque channel, else bg_data.
- Collision: live accumulator coll_acc[i-1] |= opaque_0 && opaque_i on every valid pixel. On frame_en: coll_frame <= coll_acc | (this cycle's hits); coll_acc <= 0. A hit in the same cycle as frame_en counts toward the closing frame.
- Loads: writes with load_addr >= SPR_W*SPR_H or load_sel >= N_SPR are ignored. Loads are legal during display; a read and write to the same texel in the same cycle returns the old value.
- pix_en low: pipeline advances, pixel_valid deasserts for that slot, and the accumulator is not updated.

## Timing
- 3-stage pipeline, latency 2: stage 0 registers hit/address/flip and bg_data; stage 1 is the synchronous RAM read; stage 2 registers priority, mux and collision into pixel_out/pixel_valid. A pixel presented at cycle t appears at t+2.
- Throughput is one pixel per clk, with no stalls.
- Reset values: pixel_out=0, pixel_valid=0, coll_frame=0, coll_acc=0, all pipeline valid bits 0. RAM contents are not reset.
- Reset mid-frame discards in-flight pixels; pixel_valid stays 0 until 2 cycles after the first pix_en following release.
- spr_x/y/en/flip are sampled at stage 0 every cycle. Upstream changes them only on frame_en.

## Structure
- Package sprite_pkg: KEY default, PIX_W, COORD_W, channel-index width function, packed-field slice helper.
- Sub-module sprite_tex_ram: single-clock simple dual-port RAM, SPR_W*SPR_H x PIX_W, registered read with read-old-on-collision. Instantiated N_SPR times in a generate loop; write enable = load_en && load_sel==i.
- Priority mux and collision OR-reduction stay in the top level.

## Test plan
- Single sprite: load channel 1 with texel value = address, place at (100,50), scan pixel (103,52) -> pixel_out = 2*64+3 = 131 two cycles later; pixel (99,52) -> bg_data.
- Flip: same setup with spr_flip[1]=1, pixel (103,52) -> texel 2*64+60 = 188.
- Priority/key: channels 0 and 1 overlap. Channel 0 texel = KEY -> channel 1 texel shown. Channel 0 texel = 16'hF800 -> 16'hF800 shown.
- Collision: opaque overlap of channels 0 and 2 on one pixel, then frame_en -> coll_frame = 3'b010. Next frame with no overlap -> 3'b000. An overlap coincident with frame_en is reported in the closing frame.
- Edge clip: sprite at x = 2047-10 -> pixels 2037..2047 hit; pixel_x = 0..53 shows bg (no wrap).
- Reset mid-stream: assert rst_n=0 for 1 cycle during a hit -> pixel_valid=0 and coll_frame=0 next cycle; output resumes 2 cycles after pix_en.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and helpers for the sprite compositor.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sprite_pkg;

    localparam int              PIX_W   = 16;
    localparam int              COORD_W = 11;
    localparam int              MAX_SPR = 8;
    localparam logic [15:0]     KEY_DEF = 16'h07E0;

    // Width of a channel-select field; a single channel still needs one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Pull channel idx's coordinate out of a packed per-channel vector
    // that has been zero-extended to MAX_SPR entries.
    function automatic logic [COORD_W-1:0] coord_at(
        input logic [MAX_SPR*COORD_W-1:0] vec,
        input int                         idx
    );
        return vec[idx*COORD_W +: COORD_W];
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel, sprite-configuration, texture-load and composited-output bundle.
// Latency: none (wiring only).
// Backpressure: none; the video path is free-running at one pixel per clock.
interface sprite_compositor_if #(
    parameter int N_SPR   = 4,
    parameter int SPR_W   = 64,
    parameter int SPR_H   = 64,
    parameter int PIX_W   = 16,
    parameter int COORD_W = 11
);
    localparam int AW = $clog2(SPR_W*SPR_H);
    localparam int SW = sprite_pkg::chan_w(N_SPR);

    logic                       pix_en;
    logic [COORD_W-1:0]         pixel_x;
    logic [COORD_W-1:0]         pixel_y;
    logic [PIX_W-1:0]           bg_data;
    logic [N_SPR*COORD_W-1:0]   spr_x;
    logic [N_SPR*COORD_W-1:0]   spr_y;
    logic [N_SPR-1:0]           spr_en;
    logic [N_SPR-1:0]           spr_flip;
    logic                       load_en;
    logic [SW-1:0]              load_sel;
    logic [AW-1:0]              load_addr;
    logic [PIX_W-1:0]           load_data;
    logic                       frame_en;
    logic [PIX_W-1:0]           pixel_out;
    logic                       pixel_valid;
    logic [N_SPR-2:0]           coll_frame;

    modport master (
        output pix_en, pixel_x, pixel_y, bg_data,
        output spr_x, spr_y, spr_en, spr_flip,
        output load_en, load_sel, load_addr, load_data, frame_en,
        input  pixel_out, pixel_valid, coll_frame
    );

    modport slave (
        input  pix_en, pixel_x, pixel_y, bg_data,
        input  spr_x, spr_y, spr_en, spr_flip,
        input  load_en, load_sel, load_addr, load_data, frame_en,
        output pixel_out, pixel_valid, coll_frame
    );

endinterface

// File: rtl/sprite_tex_ram.sv
// Per-channel texture store: simple dual-port RAM, one write and one read port.
// Latency: 1 cycle registered read; a same-address write returns the old texel.
// Backpressure: none; accepts a write and a read every cycle.
module sprite_tex_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Write and read share the edge, so a colliding read sees the pre-write value.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sprite_compositor.sv
// N-channel sprite compositor: hit test, colour-key priority mux, ch0 collisions.
// Latency: 2 cycles from pixel in to pixel_out/pixel_valid/coll_frame update.
// Backpressure: none; one pixel per clock, pix_en low just leaves an empty slot.
module sprite_compositor #(
    parameter int              N_SPR   = 4,
    parameter int              SPR_W   = 64,
    parameter int              SPR_H   = 64,
    parameter int              PIX_W   = sprite_pkg::PIX_W,
    parameter int              COORD_W = sprite_pkg::COORD_W,
    parameter logic [PIX_W-1:0] KEY    = PIX_W'(sprite_pkg::KEY_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    sprite_compositor_if.slave bus
);
    import sprite_pkg::*;

    localparam int DEPTH = SPR_W*SPR_H;
    localparam int AW    = $clog2(DEPTH);
    localparam int TXW   = $clog2(SPR_W);
    localparam int TYW   = $clog2(SPR_H);
    localparam int SW    = chan_w(N_SPR);

    logic [MAX_SPR*COORD_W-1:0] w_x_ext, w_y_ext;
    logic [COORD_W:0]           w_dx [N_SPR];
    logic [COORD_W:0]           w_dy [N_SPR];
    logic [TXW-1:0]             w_tx [N_SPR];
    logic [AW-1:0]              w_raddr [N_SPR];
    logic [N_SPR-1:0]           w_hit;
    logic                       w_load_ok;
    logic [PIX_W-1:0]           w_tex [N_SPR];
    logic [N_SPR-1:0]           w_opq;
    logic [PIX_W-1:0]           w_pix;
    logic [N_SPR-2:0]           w_coll;

    logic                       r_s0_vld;
    logic                       r_s0_frm;
    logic [N_SPR-1:0]           r_s0_hit;
    logic [PIX_W-1:0]           r_s0_bg;
    logic [PIX_W-1:0]           r_pixel_out;
    logic                       r_pixel_valid;
    logic [N_SPR-2:0]           r_coll_acc;
    logic [N_SPR-2:0]           r_coll_frame;

    // Hit test and texel address; the extra top bit of dx/dy is the borrow,
    // which rejects pixels left of/above the sprite instead of wrapping.
    always_comb begin
        w_x_ext = '0;
        w_y_ext = '0;
        w_x_ext[N_SPR*COORD_W-1:0] = bus.spr_x;
        w_y_ext[N_SPR*COORD_W-1:0] = bus.spr_y;
        w_dx    = '{default: '0};
        w_dy    = '{default: '0};
        w_tx    = '{default: '0};
        w_raddr = '{default: '0};
        w_hit   = '0;
        for (int i = 0; i < N_SPR; i++) begin
            w_dx[i]  = {1'b0, bus.pixel_x} - {1'b0, coord_at(w_x_ext, i)};
            w_dy[i]  = {1'b0, bus.pixel_y} - {1'b0, coord_at(w_y_ext, i)};
            w_hit[i] = bus.spr_en[i]
                     && !w_dx[i][COORD_W] && (w_dx[i] < (COORD_W+1)'(SPR_W))
                     && !w_dy[i][COORD_W] && (w_dy[i] < (COORD_W+1)'(SPR_H));
            w_tx[i]  = bus.spr_flip[i] ? (TXW'(SPR_W-1) - w_dx[i][TXW-1:0])
                                       : w_dx[i][TXW-1:0];
            w_raddr[i] = AW'(w_dy[i][TYW-1:0]) * AW'(SPR_W) + AW'(w_tx[i]);
        end
    end

    assign w_load_ok = bus.load_en
                    && ({1'b0, bus.load_addr} < (AW+1)'(DEPTH))
                    && ({1'b0, bus.load_sel}  < (SW+1)'(N_SPR));

    for (genvar g = 0; g < N_SPR; g++) begin : g_ram
        sprite_tex_ram #(
            .DEPTH (DEPTH),
            .AW    (AW),
            .DW    (PIX_W)
        ) u_ram (
            .clk     (clk),
            .i_we    (w_load_ok && (bus.load_sel == SW'(g))),
            .i_waddr (bus.load_addr),
            .i_wdata (bus.load_data),
            .i_raddr (w_raddr[g]),
            .o_rdata (w_tex[g])
        );
    end

    // Stage 0: carry hit flags, background and frame marker alongside the RAM read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s0_vld <= 1'b0;
            r_s0_frm <= 1'b0;
            r_s0_hit <= '0;
            r_s0_bg  <= '0;
        end else begin
            r_s0_vld <= bus.pix_en;
            r_s0_frm <= bus.frame_en;
            r_s0_hit <= w_hit;
            r_s0_bg  <= bus.pix_en ? bus.bg_data : r_s0_bg;
        end
    end

    // Priority: walk from the highest index down so channel 0 wins last;
    // collisions only count on valid pixels.
    always_comb begin
        w_opq  = '0;
        w_coll = '0;
        w_pix  = r_s0_bg;
        for (int i = N_SPR-1; i >= 0; i--) begin
            w_opq[i] = r_s0_hit[i] && (w_tex[i] != KEY);
            if (w_opq[i]) begin
                w_pix = w_tex[i];
            end
        end
        for (int i = 1; i < N_SPR; i++) begin
            w_coll[i-1] = r_s0_vld && w_opq[0] && w_opq[i];
        end
    end

    // Output stage; frame_en travels with its pixel, so that pixel closes the frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pixel_out   <= '0;
            r_pixel_valid <= 1'b0;
            r_coll_acc    <= '0;
            r_coll_frame  <= '0;
        end else begin
            r_pixel_valid <= r_s0_vld;
            if (r_s0_vld) begin
                r_pixel_out <= w_pix;
            end
            if (r_s0_frm) begin
                r_coll_frame <= r_coll_acc | w_coll;
                r_coll_acc   <= '0;
            end else begin
                r_coll_acc   <= r_coll_acc | w_coll;
            end
        end
    end

    assign bus.pixel_out   = r_pixel_out;
    assign bus.pixel_valid = r_pixel_valid;
    assign bus.coll_frame  = r_coll_frame;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: placement, flip, priority/key, collisions,
// edge clipping and mid-stream reset, each against hand-computed values.
module tb_sprite_compositor;
    localparam int          N   = 4;
    localparam int          CW  = 11;
    localparam logic [15:0] KEY = sprite_pkg::KEY_DEF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sprite_compositor_if #(.N_SPR(N), .SPR_W(64), .SPR_H(64), .PIX_W(16), .COORD_W(CW)) bus ();

    sprite_compositor #(
        .N_SPR(N), .SPR_W(64), .SPR_H(64), .PIX_W(16), .COORD_W(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_spr(input int i, input int x, input int y);
        bus.spr_x[i*CW +: CW] = CW'(x);
        bus.spr_y[i*CW +: CW] = CW'(y);
    endtask

    task automatic fill(input int sel, input bit use_addr, input logic [15:0] val);
        for (int a = 0; a < 4096; a++) begin
            bus.load_en   = 1'b1;
            bus.load_sel  = 2'(sel);
            bus.load_addr = 12'(a);
            bus.load_data = use_addr ? 16'(a) : val;
            tick();
        end
        bus.load_en = 1'b0;
    endtask

    task automatic load1(input int sel, input int addr, input logic [15:0] val);
        bus.load_en   = 1'b1;
        bus.load_sel  = 2'(sel);
        bus.load_addr = 12'(addr);
        bus.load_data = val;
        tick();
        bus.load_en = 1'b0;
    endtask

    // Present one pixel, then check it two edges later.
    task automatic pix(input string tag, input int x, input int y, input logic [15:0] bg,
                       input logic fe, input logic [15:0] exp);
        bus.pix_en   = 1'b1;
        bus.pixel_x  = CW'(x);
        bus.pixel_y  = CW'(y);
        bus.bg_data  = bg;
        bus.frame_en = fe;
        tick();
        bus.pix_en   = 1'b0;
        bus.frame_en = 1'b0;
        tick();
        chk({tag, "_vld"}, 32'(bus.pixel_valid), 32'd1);
        chk({tag, "_pix"}, 32'(bus.pixel_out), 32'(exp));
    endtask

    task automatic frame;
        bus.frame_en = 1'b1;
        tick();
        bus.frame_en = 1'b0;
        tick();
    endtask

    initial begin
        bus.pix_en = 1'b0;  bus.pixel_x = '0;  bus.pixel_y = '0;  bus.bg_data = '0;
        bus.spr_x  = '0;    bus.spr_y   = '0;  bus.spr_en  = '0;  bus.spr_flip = '0;
        bus.load_en = 1'b0; bus.load_sel = '0; bus.load_addr = '0; bus.load_data = '0;
        bus.frame_en = 1'b0;

        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(bus.pixel_valid), 32'd0);
        chk("rst_pixel", 32'(bus.pixel_out),   32'd0);
        chk("rst_coll",  32'(bus.coll_frame),  32'd0);
        rst_n = 1'b1;
        tick();

        fill(0, 1'b0, KEY);
        fill(1, 1'b1, 16'h0000);
        fill(2, 1'b0, KEY);
        fill(3, 1'b0, KEY);

        // Single sprite on channel 1 at (100,50)
        set_spr(1, 100, 50);
        bus.spr_en = 4'b0010;
        pix("single",     103, 52,  16'h1234, 1'b0, 16'd131);
        pix("left_of",     99, 52,  16'hABCD, 1'b0, 16'hABCD);
        pix("right_edge", 163, 52,  16'h1111, 1'b0, 16'd191);
        pix("right_out",  164, 52,  16'h2222, 1'b0, 16'h2222);
        pix("bottom",     103, 113, 16'h3333, 1'b0, 16'd4035);
        pix("below",      103, 114, 16'h4444, 1'b0, 16'h4444);

        // Horizontal mirror
        bus.spr_flip = 4'b0010;
        pix("flip",       103, 52,  16'h5555, 1'b0, 16'd188);
        pix("flip_left",  100, 52,  16'h5555, 1'b0, 16'd191);
        bus.spr_flip = 4'b0000;

        // Priority and colour key: channel 0 over channel 1
        set_spr(0, 100, 50);
        bus.spr_en = 4'b0011;
        pix("key_through", 103, 52, 16'h6666, 1'b0, 16'd131);
        load1(0, 131, 16'hF800);
        pix("ch0_wins",    103, 52, 16'h6666, 1'b0, 16'hF800);
        frame();
        chk("coll_ch1", 32'(bus.coll_frame), 32'b001);

        // Collision of channel 0 with channel 2
        set_spr(2, 100, 50);
        load1(2, 131, 16'h001F);
        bus.spr_en = 4'b0101;
        pix("coll_pix", 103, 52, 16'h7777, 1'b0, 16'hF800);
        frame();
        chk("coll_ch2", 32'(bus.coll_frame), 32'b010);
        pix("no_ovl",   104, 52, 16'h0042, 1'b0, 16'h0042);
        frame();
        chk("coll_clear", 32'(bus.coll_frame), 32'b000);

        // Overlapping pixel with pix_en low must not accumulate
        bus.pix_en  = 1'b0;
        bus.pixel_x = 11'd103;
        bus.pixel_y = 11'd52;
        tick();
        tick();
        chk("gap_valid", 32'(bus.pixel_valid), 32'd0);
        frame();
        chk("gap_coll", 32'(bus.coll_frame), 32'b000);

        // Overlap coincident with frame_en belongs to the closing frame
        pix("coinc", 103, 52, 16'h8888, 1'b1, 16'hF800);
        chk("coinc_coll", 32'(bus.coll_frame), 32'b010);
        frame();
        chk("coinc_next", 32'(bus.coll_frame), 32'b000);

        // Right screen edge: clipped, never wraps to x=0
        bus.spr_en = 4'b0010;
        set_spr(1, 2037, 50);
        pix("clip_l",   2037, 52, 16'h9999, 1'b0, 16'd128);
        pix("clip_r",   2047, 52, 16'h9999, 1'b0, 16'd138);
        pix("clip_pre", 2036, 52, 16'hAAAA, 1'b0, 16'hAAAA);
        pix("nowrap0",     0, 52, 16'hBBBB, 1'b0, 16'hBBBB);
        pix("nowrap53",   53, 52, 16'hCCCC, 1'b0, 16'hCCCC);

        // Reset while a hit pixel is in flight
        bus.spr_en = 4'b0101;
        pix("pre_rst", 103, 52, 16'hDDDD, 1'b0, 16'hF800);
        frame();
        chk("pre_rst_coll", 32'(bus.coll_frame), 32'b010);
        bus.pix_en  = 1'b1;
        bus.pixel_x = 11'd103;
        bus.pixel_y = 11'd52;
        tick();
        rst_n      = 1'b0;
        bus.pix_en = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(bus.pixel_valid), 32'd0);
        chk("mid_rst_coll",  32'(bus.coll_frame),  32'd0);
        chk("mid_rst_pixel", 32'(bus.pixel_out),   32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", 32'(bus.pixel_valid), 32'd0);
        pix("resume", 103, 52, 16'hEEEE, 1'b0, 16'hF800);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
